// File: rtl/st_adapter_pkg.sv
`default_nettype none
// ============================================================================
// st_adapter_pkg : shared types and helpers for the ST channel filter adapter
// Rev 1.0
// ============================================================================
package st_adapter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    // A channel is legal when it lies in [offset, offset + max_ch].
    function automatic logic chan_legal(
        input logic [31:0] ch,
        input logic [31:0] offset,
        input logic [31:0] max_ch
    );
        return (ch >= offset) && ((ch - offset) <= max_ch);
    endfunction

endpackage
`default_nettype wire

// File: rtl/st_skid_buffer.sv
`default_nettype none
// ============================================================================
// st_skid_buffer : 2-entry valid/ready register stage with registered ready
// Rev 1.0
// ============================================================================
module st_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_cnt;
    logic         r_ready;
    logic         w_push;
    logic         w_pop;
    logic [1:0]   w_cnt_nxt;

    assign w_push    = i_valid & r_ready;
    assign w_pop     = (r_cnt != 2'd0) & i_ready;
    assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= 2'd0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_cnt   <= w_cnt_nxt;
            // Ready looks one beat ahead so the upstream never sees out_ready.
            r_ready <= (w_cnt_nxt != 2'd2);
        end
    end

    assign o_ready = r_ready;
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/st_channel_filter_adapter.sv
`default_nettype none
// ============================================================================
// st_channel_filter_adapter : remaps/filters ST channels per packet or beat,
//                             registered output via skid buffer, drop counter
// Rev 1.0
// ============================================================================
module st_channel_filter_adapter
    import st_adapter_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int IN_CHANNEL_W   = 8,
    parameter int OUT_CHANNEL_W  = 1,
    parameter int CHANNEL_OFFSET = 0,
    parameter int MAX_CHANNEL    = 0,
    parameter int PKT_DROP       = 1,
    parameter int CNT_W          = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     in_ready,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [IN_CHANNEL_W-1:0]  in_channel,
    input  logic                     in_startofpacket,
    input  logic                     in_endofpacket,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [OUT_CHANNEL_W-1:0] out_channel,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    input  logic                     clear_count,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     protocol_err
);

    localparam int SKID_W = DATA_W + OUT_CHANNEL_W + 2;

    logic                     w_acc;
    logic                     w_legal;
    logic                     w_fwd;
    logic                     w_drop;
    logic                     w_err;
    logic [OUT_CHANNEL_W-1:0] w_remap;
    logic [OUT_CHANNEL_W-1:0] w_fwd_ch;
    logic [SKID_W-1:0]        w_skid_q;
    logic [CNT_W-1:0]         r_drop_count;
    logic                     r_protocol_err;

    assign w_acc   = in_valid & in_ready;
    assign w_legal = chan_legal(32'(in_channel), 32'(CHANNEL_OFFSET), 32'(MAX_CHANNEL));
    assign w_remap = OUT_CHANNEL_W'(in_channel - IN_CHANNEL_W'(CHANNEL_OFFSET));

    generate
        if (PKT_DROP != 0) begin : g_pkt
            state_e                   r_state;
            state_e                   w_state_nxt;
            logic [OUT_CHANNEL_W-1:0] r_ch;

            // Any SOP restarts evaluation as if IDLE, even mid-packet.
            always_comb begin
                w_fwd       = 1'b0;
                w_drop      = 1'b0;
                w_err       = 1'b0;
                w_fwd_ch    = w_remap;
                w_state_nxt = r_state;
                if (w_acc) begin
                    if (in_startofpacket) begin
                        w_err = (r_state != ST_IDLE);
                        if (w_legal) begin
                            w_fwd       = 1'b1;
                            w_state_nxt = in_endofpacket ? ST_IDLE : ST_PASS;
                        end else begin
                            w_drop      = 1'b1;
                            w_state_nxt = in_endofpacket ? ST_IDLE : ST_DROP;
                        end
                    end else begin
                        case (r_state)
                            ST_PASS: begin
                                w_fwd    = 1'b1;
                                w_fwd_ch = r_ch;
                                if (in_endofpacket) w_state_nxt = ST_IDLE;
                            end
                            ST_DROP: begin
                                if (in_endofpacket) w_state_nxt = ST_IDLE;
                            end
                            default: w_err = 1'b1;
                        endcase
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state <= ST_IDLE;
                    r_ch    <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    if (w_acc && in_startofpacket && w_legal) r_ch <= w_remap;
                end
            end
        end else begin : g_beat
            assign w_fwd    = w_acc & w_legal;
            assign w_drop   = w_acc & ~w_legal;
            assign w_err    = 1'b0;
            assign w_fwd_ch = w_remap;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_count   <= '0;
            r_protocol_err <= 1'b0;
        end else if (clear_count) begin
            r_drop_count   <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            if (w_drop && (r_drop_count != {CNT_W{1'b1}})) r_drop_count <= r_drop_count + 1'b1;
            if (w_err) r_protocol_err <= 1'b1;
        end
    end

    assign drop_count   = r_drop_count;
    assign protocol_err = r_protocol_err;

    st_skid_buffer #(
        .W (SKID_W)
    ) u_skid (
        .clk     (clk),
        .rst     (reset),
        .i_valid (w_fwd),
        .i_data  ({in_data, w_fwd_ch, in_startofpacket, in_endofpacket}),
        .o_ready (in_ready),
        .o_valid (out_valid),
        .o_data  (w_skid_q),
        .i_ready (out_ready)
    );

    assign {out_data, out_channel, out_startofpacket, out_endofpacket} = w_skid_q;

endmodule
`default_nettype wire

// File: tb/tb_st_channel_filter_adapter.sv
`default_nettype none
// ============================================================================
// tb_st_channel_filter_adapter : self-checking bench, three parameterisations
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_st_channel_filter_adapter;

    typedef struct packed {
        logic [7:0] data;
        logic       ch;
        logic       sop;
        logic       eop;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       iv   [3];
    logic [7:0] idat [3];
    logic [7:0] ich  [3];
    logic       isop [3];
    logic       ieop [3];
    logic       ordy [3];
    logic       clr  [3];
    logic       irdy [3];
    logic       ov   [3];
    logic [7:0] od   [3];
    logic       och  [3];
    logic       osop [3];
    logic       oeop [3];
    logic       perr [3];
    logic [15:0] dc0;
    logic [1:0]  dc1;
    logic [15:0] dc2;

    int n_checks = 0;
    int n_errors = 0;

    // d0: defaults (per packet, ch0 only); d1: offset 4, max 1, 2-bit count; d2: per beat, ch0..1
    st_channel_filter_adapter u_a (
        .clk(clk), .reset(reset), .in_ready(irdy[0]), .in_valid(iv[0]), .in_data(idat[0]),
        .in_channel(ich[0]), .in_startofpacket(isop[0]), .in_endofpacket(ieop[0]),
        .out_ready(ordy[0]), .out_valid(ov[0]), .out_data(od[0]), .out_channel(och[0]),
        .out_startofpacket(osop[0]), .out_endofpacket(oeop[0]), .clear_count(clr[0]),
        .drop_count(dc0), .protocol_err(perr[0]));

    st_channel_filter_adapter #(.CHANNEL_OFFSET(4), .MAX_CHANNEL(1), .CNT_W(2)) u_b (
        .clk(clk), .reset(reset), .in_ready(irdy[1]), .in_valid(iv[1]), .in_data(idat[1]),
        .in_channel(ich[1]), .in_startofpacket(isop[1]), .in_endofpacket(ieop[1]),
        .out_ready(ordy[1]), .out_valid(ov[1]), .out_data(od[1]), .out_channel(och[1]),
        .out_startofpacket(osop[1]), .out_endofpacket(oeop[1]), .clear_count(clr[1]),
        .drop_count(dc1), .protocol_err(perr[1]));

    st_channel_filter_adapter #(.MAX_CHANNEL(1), .PKT_DROP(0)) u_c (
        .clk(clk), .reset(reset), .in_ready(irdy[2]), .in_valid(iv[2]), .in_data(idat[2]),
        .in_channel(ich[2]), .in_startofpacket(isop[2]), .in_endofpacket(ieop[2]),
        .out_ready(ordy[2]), .out_valid(ov[2]), .out_data(od[2]), .out_channel(och[2]),
        .out_startofpacket(osop[2]), .out_endofpacket(oeop[2]), .clear_count(clr[2]),
        .drop_count(dc2), .protocol_err(perr[2]));

    // ---------------- reference model helpers ----------------
    function automatic int off_of(int d);
        return (d == 1) ? 4 : 0;
    endfunction

    function automatic int max_of(int d);
        return (d == 0) ? 0 : 1;
    endfunction

    function automatic bit chan_ok(int d, int ch);
        return (ch >= off_of(d)) && ((ch - off_of(d)) <= max_of(d));
    endfunction

    function automatic logic remap(int d, int ch);
        return 1'((ch - off_of(d)) % 2);
    endfunction

    function automatic logic [15:0] get_dc(int d);
        if (d == 0) return dc0;
        if (d == 1) return {14'b0, dc1};
        return dc2;
    endfunction

    // ---------------- output monitor / scoreboard ----------------
    beat_t exp_q[$];
    int    mon_d  = 0;
    bit    mon_en = 1'b0;
    bit    prev_stall = 1'b0;
    beat_t prev_beat;
    beat_t mon_got;
    beat_t mon_exp;

    always @(negedge clk) begin
        if (mon_en) begin
            mon_got = {od[mon_d], och[mon_d], osop[mon_d], oeop[mon_d]};
            if (prev_stall) begin
                n_checks++;
                if (ov[mon_d] !== 1'b1 || mon_got !== prev_beat) begin
                    n_errors++;
                    $display("FAIL stall_hold dut%0d: got valid=%b beat=%h, need valid=1 beat=%h",
                             mon_d, ov[mon_d], mon_got, prev_beat);
                end
            end
            if (ov[mon_d] === 1'b1 && ordy[mon_d] === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_out dut%0d: got beat=%h, need no output", mon_d, mon_got);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp) begin
                        n_errors++;
                        $display("FAIL out_beat dut%0d: got %h, need %h", mon_d, mon_got, mon_exp);
                    end
                end
            end
            prev_stall = (ov[mon_d] === 1'b1) && (ordy[mon_d] !== 1'b1);
            prev_beat  = mon_got;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- stimulus helpers (all run at posedge + 1) ----------------
    task automatic cycles(int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(int d);
        iv[d] = 1'b0; isop[d] = 1'b0; ieop[d] = 1'b0;
    endtask

    task automatic send_beat(int d, logic [7:0] data, logic [7:0] ch, logic sop, logic eop);
        int waited = 0;
        iv[d] = 1'b1; idat[d] = data; ich[d] = ch; isop[d] = sop; ieop[d] = eop;
        while (irdy[d] !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        n_checks++;
        if (irdy[d] !== 1'b1) begin
            n_errors++;
            $display("FAIL accept_timeout dut%0d: in_ready=%b, need 1", d, irdy[d]);
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_clear(int d);
        clr[d] = 1'b1;
        @(posedge clk); #1;
        clr[d] = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_timeout: %0d beats still pending, need 0", exp_q.size());
            exp_q.delete();
        end
        cycles(3);
    endtask

    // Packet-level model: a whole packet is kept or dropped on its SOP channel
    // (d0/d1); d2 judges each beat on its own channel.
    task automatic send_packet(int d, int ch, int len, bit mid_change, output int drops);
        bit    legal;
        beat_t b;
        legal = chan_ok(d, ch);
        drops = 0;
        for (int k = 0; k < len; k++) begin
            int         bch;
            logic [7:0] dat;
            bch = (k == 0 || !mid_change) ? ch : int'($urandom_range(0, 7));
            dat = 8'($urandom);
            b.data = dat; b.sop = (k == 0); b.eop = (k == len - 1);
            if (d == 2) begin
                b.ch = remap(d, bch);
                if (chan_ok(d, bch)) exp_q.push_back(b);
                else                 drops++;
            end else if (legal) begin
                b.ch = remap(d, ch);
                exp_q.push_back(b);
            end
            send_beat(d, dat, 8'(bch), k == 0, k == len - 1);
        end
        if (d != 2 && !legal) drops = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 0; idat[d] = 0; ich[d] = 0; isop[d] = 0; ieop[d] = 0; ordy[d] = 0; clr[d] = 0;
        end
        cycles(2);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (ov[d] !== 1'b0 || od[d] !== 8'h00 || irdy[d] !== 1'b0 || perr[d] !== 1'b0 ||
                get_dc(d) !== 16'd0) begin
                n_errors++;
                $display("FAIL reset_state dut%0d: valid=%b data=%h in_ready=%b err=%b cnt=%0d, need all 0",
                         d, ov[d], od[d], irdy[d], perr[d], get_dc(d));
            end
        end
        reset = 1'b0;
        cycles(1);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (irdy[d] !== 1'b1) begin
                n_errors++;
                $display("FAIL ready_after_reset dut%0d: in_ready=%b, need 1", d, irdy[d]);
            end
            ordy[d] = 1'b1;
        end
    endtask

    task automatic test_basic_pkt();
        logic [7:0] dat [4];
        beat_t      b;
        mon_d = 0; mon_en = 1'b1;
        for (int k = 0; k < 4; k++) dat[k] = 8'($urandom);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (irdy[0] !== 1'b1) begin
                n_errors++;
                $display("FAIL in_ready_drop beat%0d: in_ready=%b, need 1", k, irdy[0]);
            end
            if (k > 0) begin
                n_checks++;
                if (ov[0] !== 1'b1 || od[0] !== dat[k-1]) begin
                    n_errors++;
                    $display("FAIL latency beat%0d: valid=%b data=%h, need valid=1 data=%h",
                             k - 1, ov[0], od[0], dat[k-1]);
                end
            end
            b.data = dat[k]; b.ch = 1'b0; b.sop = (k == 0); b.eop = (k == 3);
            exp_q.push_back(b);
            send_beat(0, dat[k], 8'd0, k == 0, k == 3);
        end
        idle(0);
        n_checks++;
        if (ov[0] !== 1'b1 || od[0] !== dat[3] || oeop[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL latency beat3: valid=%b data=%h eop=%b, need valid=1 data=%h eop=1",
                     ov[0], od[0], oeop[0], dat[3]);
        end
        drain();
    endtask

    task automatic test_drop_pkt();
        int drops;
        int total = 0;
        mon_d = 0;
        pulse_clear(0);
        send_packet(0, 3, 4, 1'b0, drops); total += drops;
        send_packet(0, 0, 4, 1'b0, drops); total += drops;
        idle(0);
        drain();
        n_checks++;
        if (dc0 !== 16'(total)) begin
            n_errors++;
            $display("FAIL drop_pkt_count: got %0d, need %0d", dc0, total);
        end
    endtask

    task automatic test_offset();
        int drops;
        int total = 0;
        mon_d = 1;
        pulse_clear(1);
        send_packet(1, 5, 3, 1'b0, drops); total += drops;
        send_packet(1, 6, 2, 1'b0, drops); total += drops;
        send_packet(1, 3, 2, 1'b0, drops); total += drops;
        idle(1);
        drain();
        n_checks++;
        if (dc1 !== 2'(total)) begin
            n_errors++;
            $display("FAIL offset_count: got %0d, need %0d", dc1, total);
        end
    endtask

    task automatic test_mid_channel();
        logic [7:0] chs [4] = '{8'd0, 8'd0, 8'd3, 8'd3};
        beat_t      b;
        mon_d = 0;
        for (int k = 0; k < 4; k++) begin
            b.data = 8'($urandom); b.ch = 1'b0; b.sop = (k == 0); b.eop = (k == 3);
            exp_q.push_back(b);
            send_beat(0, b.data, chs[k], b.sop, b.eop);
        end
        idle(0);
        drain();
    endtask

    task automatic test_protocol();
        beat_t b;
        mon_d = 0;
        pulse_clear(0);
        b.ch = 1'b0;
        b.data = 8'h11; b.sop = 1'b1; b.eop = 1'b0; exp_q.push_back(b);
        send_beat(0, 8'h11, 8'd0, 1'b1, 1'b0);
        b.data = 8'h22; b.sop = 1'b1; b.eop = 1'b1; exp_q.push_back(b);
        send_beat(0, 8'h22, 8'd0, 1'b1, 1'b1);
        idle(0);
        drain();
        n_checks++;
        if (perr[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL sop_in_pass_err: got %b, need 1", perr[0]);
        end
        send_beat(0, 8'h33, 8'd3, 1'b1, 1'b1);
        idle(0);
        n_checks++;
        if (dc0 !== 16'd1) begin
            n_errors++;
            $display("FAIL drop_before_clear: got %0d, need 1", dc0);
        end
        clr[0] = 1'b1;
        send_beat(0, 8'h44, 8'd3, 1'b1, 1'b1);
        clr[0] = 1'b0;
        idle(0);
        n_checks++;
        if (dc0 !== 16'd0 || perr[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_wins: cnt=%0d err=%b, need cnt=0 err=0", dc0, perr[0]);
        end
        send_beat(0, 8'h55, 8'd0, 1'b0, 1'b0);
        idle(0);
        cycles(3);
        n_checks++;
        if (perr[0] !== 1'b1 || dc0 !== 16'd0) begin
            n_errors++;
            $display("FAIL no_sop_err: err=%b cnt=%0d, need err=1 cnt=0", perr[0], dc0);
        end
    endtask

    task automatic test_saturate();
        mon_d = 1;
        pulse_clear(1);
        for (int i = 1; i <= 5; i++) begin
            send_beat(1, 8'($urandom), 8'd7, 1'b1, 1'b1);
            idle(1);
            n_checks++;
            if (dc1 !== 2'((i > 3) ? 3 : i)) begin
                n_errors++;
                $display("FAIL saturate drop%0d: got %0d, need %0d", i, dc1, (i > 3) ? 3 : i);
            end
        end
    endtask

    task automatic test_random(int d);
        int drops;
        int total = 0;
        int sent  = 0;
        bit done  = 1'b0;
        mon_d = d;
        pulse_clear(d);
        fork
            begin
                while (sent < 1000) begin
                    int len;
                    int ch;
                    len = int'($urandom_range(1, 6));
                    ch  = (d == 2) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 2));
                    send_packet(d, ch, len, 1'b1, drops);
                    total += drops;
                    sent  += len;
                    idle(d);
                    if ($urandom_range(0, 3) == 0) cycles(1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    ordy[d] = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        ordy[d] = 1'b1;
        drain();
        n_checks++;
        if (get_dc(d) !== 16'(total)) begin
            n_errors++;
            $display("FAIL random_count dut%0d: got %0d, need %0d", d, get_dc(d), total);
        end
    endtask

    task automatic test_reset_midpkt();
        mon_en = 1'b0;
        ordy[0] = 1'b0;
        send_beat(0, 8'h66, 8'd0, 1'b1, 1'b0);
        send_beat(0, 8'h77, 8'd0, 1'b0, 1'b0);
        idle(0);
        n_checks++;
        if (ov[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL stalled_before_reset: valid=%b, need 1", ov[0]);
        end
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        n_checks++;
        if (ov[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flush: valid=%b, need 0", ov[0]);
        end
        ordy[0] = 1'b1;
        cycles(1);
        send_beat(0, 8'h88, 8'd0, 1'b0, 1'b1);
        idle(0);
        cycles(2);
        n_checks++;
        if (perr[0] !== 1'b1 || ov[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset: err=%b valid=%b, need err=1 valid=0", perr[0], ov[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic_pkt();
        test_drop_pkt();
        test_offset();
        test_mid_channel();
        test_protocol();
        test_saturate();
        test_random(0);
        test_random(2);
        test_reset_midpkt();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
